imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory port; the CPU core only ever reads this port.
- Accepts a byte stream over a valid/ready handshake and assembles it into N-bit words.
- Writes the words into the instruction memory block, starting at LOAD_BASE, and reports when the load is complete.
- Sits between an external byte source (host link or test bench) and the instruction memory's address/in/write_en inputs. While busy is high, the CPU is held off.

Parameters:
- N, 16, word width in bits; also the memory address width.
- M, 1024, memory depth in words.
- LOAD_BASE, 1, first address written. Matches the CPU's program counter value after reset.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load. Ignored unless the FSM is in IDLE, DONE or ERR.
- in_valid  input  1  byte source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts in_data this cycle. A transfer occurs when in_valid and in_ready are both high.
- mem_addr  output  N  write address to instruction memory.
- mem_din  output  N  write data to instruction memory.
- mem_we  output  1  write enable; a single-cycle pulse per word.
- busy  output  1  high from the cycle after start until the load terminates.
- done  output  1  load completed successfully; held until next start or reset.
- err  output  1  load aborted; held until next start or reset.
- words_loaded  output  N  count of words written in the current/last load.

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=LOAD_BASE, mem_din=0, busy=0, done=0, err=0, words_loaded=0, FSM=IDLE.
- Reset asserted mid-load aborts immediately. No further write occurs, and a partial image is left in memory.
- Stream format, all fields big-endian:
  - LEN_HI, LEN_LO: 16-bit word count L.
  - L words, each as two bytes, high byte first.
  - Optional checksum byte (see Optional Feature).
- Byte packing: for N>16, the upper bits of each word are zero-filled and only the low 16 bits are loaded. For N<16, words are truncated to N bits. The default N=16 is exact.
- FSM states:
  - IDLE: in_ready=0. On start: done=0, err=0, words_loaded=0, mem_addr=LOAD_BASE, busy=1, go to LEN_HI.
  - LEN_HI: in_ready=1. On transfer, latch the byte into len[15:8], go to LEN_LO.
  - LEN_LO: in_ready=1. On transfer, latch len[7:0], then:
    - if L > M-LOAD_BASE, go to ERR;
    - else if L==0, go to CHK or DONE;
    - else go to DATA_HI.
  - DATA_HI: in_ready=1. On transfer, latch the high byte, go to DATA_LO.
  - DATA_LO: in_ready=1. On transfer, form mem_din={hi,lo} and go to WRITE.
  - WRITE: in_ready=0, mem_we=1 for exactly this cycle, with mem_addr/mem_din stable. At exit, mem_addr+1 and words_loaded+1. If words_loaded+1==L, go to CHK or DONE; else go to DATA_HI.
  - DONE: busy=0, done=1, in_ready=0.
  - ERR: busy=0, err=1, in_ready=0. No mem_we is ever issued after entering ERR.
- Timing: mem_we rises the cycle after the accepting edge of the low byte. Peak throughput is one word per 3 cycles.
- in_valid may drop between bytes at any point; the FSM simply waits, with no timeout.
- A start pulse during LEN_HI..WRITE is ignored.
- Address never wraps. The length check guarantees the last address is ≤ M-1.
- Checksum accumulates as the XOR of every accepted byte, including the length bytes.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: after the last WRITE (or LEN_LO when L=0), state CHK has in_ready=1 and expects one byte.
  - If the byte equals the XOR of all preceding bytes, go to DONE; else go to ERR.
  - Words already written stay in memory.
- Not defined: the CHK state does not exist. The terminal word goes straight to DONE, and a trailing byte is not accepted (in_ready=0).

Test Plan:
- Reset, then start with stream 00 03 | 12 34 | AB CD | 00 01 -> three mem_we pulses at addr 1,2,3 with data 1234, ABCD, 0001; done=1, words_loaded=3, busy=0.
- Same stream with in_valid toggled every other cycle -> identical writes and final state; mem_we is never asserted while in_ready=1.
- Length 03 FF (1023 = M-1) is accepted, last write at addr 1023. Length 04 00 (1024) -> err=1 after LEN_LO, zero mem_we pulses.
- Length 00 00 -> done=1, no writes. A start pulse mid-load is ignored; a second start after done reloads from addr 1 with words_loaded reset to 0.
- rst_n pulled low between DATA_HI and DATA_LO of word 2 -> all outputs return to reset values asynchronously and no write for word 2 occurs.
- With IMEM_LOADER_CHECKSUM_EN, stream 00 01 12 34 27 (00^01^12^34=27) -> done=1. The same stream with checksum 28 -> err=1 after the single write at addr 1.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory loader: receives a big-endian byte stream (length, then words)
// over valid/ready and writes the words into instruction memory from LOAD_BASE upward.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned N         = 16,
  parameter int unsigned M         = 1024,
  parameter int unsigned LOAD_BASE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_din,
  output logic         mem_we,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] words_loaded
);

  // Largest word count that still fits between LOAD_BASE and the top of memory.
  localparam logic [31:0] MaxLen = 32'(M - LOAD_BASE);

  typedef enum logic [3:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StWrite,
`ifdef IMEM_LOADER_CHECKSUM_EN
    StChk,
`endif
    StDone,
    StErr
  } state_e;

  state_e      state;
  logic [15:0] len;
  logic [7:0]  hi_byte;
  logic [15:0] len_next;
  logic        xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign xfer     = in_valid && in_ready;
  assign len_next = {len[15:8], in_data};

  // Load sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= StIdle;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= N'(LOAD_BASE);
      mem_din      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      len          <= '0;
      hi_byte      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (xfer) csum <= csum ^ in_data;
`endif
      case (state)
        StIdle, StDone, StErr: begin
          if (start) begin
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            mem_addr     <= N'(LOAD_BASE);
            busy         <= 1'b1;
            in_ready     <= 1'b1;
            state        <= StLenHi;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
          end
        end
        StLenHi: begin
          if (xfer) begin
            len[15:8] <= in_data;
            state     <= StLenLo;
          end
        end
        StLenLo: begin
          if (xfer) begin
            len[7:0] <= in_data;
            if (32'(len_next) > MaxLen) begin
              in_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
              state    <= StErr;
            end else if (len_next == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= StChk;
`else
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= StDone;
`endif
            end else begin
              state <= StDataHi;
            end
          end
        end
        StDataHi: begin
          if (xfer) begin
            hi_byte <= in_data;
            state   <= StDataLo;
          end
        end
        StDataLo: begin
          if (xfer) begin
            // Zero-extends or truncates the 16-bit word to N bits.
            mem_din  <= N'({hi_byte, in_data});
            mem_we   <= 1'b1;
            in_ready <= 1'b0;
            state    <= StWrite;
          end
        end
        StWrite: begin
          mem_addr     <= mem_addr + N'(1);
          words_loaded <= words_loaded + N'(1);
          if (32'(words_loaded) + 32'd1 == 32'(len)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            in_ready <= 1'b1;
            state    <= StChk;
`else
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= StDone;
`endif
          end else begin
            in_ready <= 1'b1;
            state    <= StDataHi;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        StChk: begin
          if (xfer) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == csum) begin
              done  <= 1'b1;
              state <= StDone;
            end else begin
              err   <= 1'b1;
              state <= StErr;
            end
          end
        end
`endif
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams against a stream-level model.
module tb_imem_loader;
  localparam int unsigned N  = 16;
  localparam int unsigned M  = 1024;
  localparam int unsigned LB = 1;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_ready;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_din;
  logic         mem_we;
  logic         busy;
  logic         done;
  logic         err;
  logic [N-1:0] words_loaded;

  int n_checks = 0;
  int n_pass = 0;

  imem_loader #(.N(N), .M(M), .LOAD_BASE(LB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Write monitor: records every memory write, counts writes overlapping in_ready.
  logic [N-1:0] got_addr[$];
  logic [N-1:0] got_data[$];
  int           overlap = 0;
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_din);
      if (in_ready === 1'b1) overlap++;
    end
  end

  // Stream-level reference model.
  logic [N-1:0] exp_addr[$];
  logic [N-1:0] exp_data[$];
  bit           exp_done, exp_err;
  int           exp_words, exp_nacc;

  function automatic void model(input bq_t s);
    int l;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    l = int'(s[0]) * 256 + int'(s[1]);
    x = s[0] ^ s[1];
    if (l > int'(M - LB)) begin
      exp_err = 1'b1; exp_done = 1'b0; exp_words = 0; exp_nacc = 2;
      return;
    end
    for (int i = 0; i < l; i++) begin
      exp_addr.push_back(N'(LB + i));
      exp_data.push_back(N'({s[2+2*i], s[3+2*i]}));
      x = x ^ s[2+2*i] ^ s[3+2*i];
    end
    exp_words = l;
    exp_nacc  = 2 + 2 * l;
    if (CsumEn) begin
      exp_nacc++;
      exp_done = (s[2+2*l] == x);
      exp_err  = !exp_done;
    end else begin
      exp_done = 1'b1;
      exp_err  = 1'b0;
    end
  endfunction

  // Appends the XOR checksum (optionally corrupted) when the feature is built in.
  function automatic bq_t add_csum(input bq_t s, input bit good);
    logic [7:0] x = 8'h00;
    bq_t r = s;
    foreach (s[i]) x ^= s[i];
    if (CsumEn) r.push_back(good ? x : x ^ 8'h01);
    return r;
  endfunction

  function automatic bq_t make_stream(input int l, input bit good);
    bq_t s;
    s.push_back(8'(l >> 8));
    s.push_back(8'(l));
    for (int i = 0; i < 2 * l; i++) s.push_back(8'($urandom_range(0, 255)));
    return add_csum(s, good);
  endfunction

  function automatic int write_errs();
    int e = 0;
    if (got_addr.size() != exp_addr.size()) e += 1000;
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) e++;
    return e;
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // mode 0: always valid, 1: valid every other cycle, 2: random gaps.
  task automatic send_bytes(input bq_t s, input int first, input int last, input int mode);
    int idx = first;
    int cyc = 0;
    while (idx < last && cyc < 20000) begin
      @(negedge clk);
      case (mode)
        0: in_valid = 1'b1;
        1: in_valid = cyc[0];
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      in_data = in_valid ? s[idx] : 8'($urandom_range(0, 255));
      if (in_valid && in_ready === 1'b1) idx++;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_term(output bit timed_out);
    int c = 0;
    while (!(done === 1'b1 || err === 1'b1) && c < 20000) begin
      @(negedge clk);
      c++;
    end
    timed_out = (c >= 20000);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_load(input bq_t s, input int mode, output bit to);
    got_addr.delete(); got_data.delete();
    model(s);
    pulse_start();
    send_bytes(s, 0, exp_nacc, mode);
    wait_term(to);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready, mem_we, mem_addr, mem_din, busy, done, err, words_loaded} !==
        {1'b0, 1'b0, N'(LB), N'(0), 1'b0, 1'b0, 1'b0, N'(0)})
      $display("FAIL reset_values got ir=%b we=%b a=%h d=%h b=%b dn=%b e=%b w=%h want a=%h rest 0",
               in_ready, mem_we, mem_addr, mem_din, busy, done, err, words_loaded, N'(LB));
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit to;
    bq_t s = add_csum('{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01}, 1'b1);
    got_addr.delete(); got_data.delete();
    model(s);
    pulse_start();
    n_checks++;
    if ({busy, in_ready} !== 2'b11) $display("FAIL basic_busy got %b want 11", {busy, in_ready});
    else n_pass++;
    send_bytes(s, 0, exp_nacc, 0);
    wait_term(to);
    n_checks++;
    if (to) $display("FAIL basic_timeout got timeout want done");
    else n_pass++;
    n_checks++;
    if (write_errs() != 0) $display("FAIL basic_writes got %0d errors want 0", write_errs());
    else n_pass++;
    n_checks++;
    if ({done, err, busy, in_ready, words_loaded} !== {1'b1, 1'b0, 1'b0, 1'b0, N'(3)})
      $display("FAIL basic_status got %b%b%b%b w=%0d want 1000 w=3",
               done, err, busy, in_ready, words_loaded);
    else n_pass++;
  endtask

  task automatic test_toggle_and_random();
    bit to;
    bq_t s;
    for (int it = 0; it < 5; it++) begin
      s = (it == 0) ? add_csum('{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01}, 1'b1)
                    : make_stream($urandom_range(1, 16), 1'b1);
      overlap = 0;
      run_load(s, (it == 0) ? 1 : 2, to);
      n_checks++;
      if (to || write_errs() != 0)
        $display("FAIL stream%0d_writes got to=%b errs=%0d want to=0 errs=0", it, to, write_errs());
      else n_pass++;
      n_checks++;
      if ({done, err, busy, words_loaded} !== {exp_done, exp_err, 1'b0, N'(exp_words)})
        $display("FAIL stream%0d_status got dn=%b e=%b b=%b w=%0d want dn=%b e=%b b=0 w=%0d",
                 it, done, err, busy, words_loaded, exp_done, exp_err, exp_words);
      else n_pass++;
      n_checks++;
      if (overlap != 0) $display("FAIL stream%0d_we_ready got %0d want 0", it, overlap);
      else n_pass++;
    end
  endtask

  task automatic test_length_bounds();
    bit to;
    int cases[3] = '{1023, 1024, 0};
    foreach (cases[k]) begin
      run_load(make_stream(cases[k], 1'b1), 0, to);
      n_checks++;
      if (to || write_errs() != 0)
        $display("FAIL len%0d_writes got to=%b errs=%0d want 0", cases[k], to, write_errs());
      else n_pass++;
      n_checks++;
      if ({done, err, busy, words_loaded} !== {exp_done, exp_err, 1'b0, N'(exp_words)})
        $display("FAIL len%0d_status got dn=%b e=%b b=%b w=%0d want dn=%b e=%b b=0 w=%0d",
                 cases[k], done, err, busy, words_loaded, exp_done, exp_err, exp_words);
      else n_pass++;
    end
  endtask

  task automatic test_start_ignored_restart();
    bit to;
    bq_t s = make_stream(3, 1'b1);
    got_addr.delete(); got_data.delete();
    model(s);
    pulse_start();
    send_bytes(s, 0, 4, 0);
    pulse_start();
    send_bytes(s, 4, exp_nacc, 2);
    wait_term(to);
    n_checks++;
    if (to || write_errs() != 0 || done !== exp_done)
      $display("FAIL start_ignored got to=%b errs=%0d dn=%b want 0 0 %b",
               to, write_errs(), done, exp_done);
    else n_pass++;
    s = make_stream(2, 1'b1);
    got_addr.delete(); got_data.delete();
    model(s);
    pulse_start();
    n_checks++;
    if ({done, err, busy, words_loaded, mem_addr} !== {1'b0, 1'b0, 1'b1, N'(0), N'(LB)})
      $display("FAIL restart_state got dn=%b e=%b b=%b w=%0d a=%0d want 0 0 1 0 %0d",
               done, err, busy, words_loaded, mem_addr, LB);
    else n_pass++;
    send_bytes(s, 0, exp_nacc, 0);
    wait_term(to);
    n_checks++;
    if (to || write_errs() != 0 || words_loaded !== N'(2))
      $display("FAIL restart_load got to=%b errs=%0d w=%0d want 0 0 2", to, write_errs(),
               words_loaded);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bq_t s = add_csum('{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01}, 1'b1);
    got_addr.delete(); got_data.delete();
    pulse_start();
    send_bytes(s, 0, 5, 0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, mem_we, mem_addr, mem_din, busy, done, err, words_loaded} !==
        {1'b0, 1'b0, N'(LB), N'(0), 1'b0, 1'b0, 1'b0, N'(0)})
      $display("FAIL midreset_values got ir=%b we=%b a=%h d=%h b=%b dn=%b e=%b w=%h want reset",
               in_ready, mem_we, mem_addr, mem_din, busy, done, err, words_loaded);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (!(got_addr.size() == 1 && got_addr[0] === N'(1) && got_data[0] === N'(16'h1234)))
      $display("FAIL midreset_writes got %0d writes want 1 (addr 1 data 1234)", got_addr.size());
    else n_pass++;
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit to;
    bq_t s;
    for (int g = 0; g < 2; g++) begin
      s = '{8'h00, 8'h01, 8'h12, 8'h34, (g == 0) ? 8'h27 : 8'h28};
      run_load(s, 0, to);
      n_checks++;
      if (to || write_errs() != 0 || {done, err} !== {g == 0, g == 1})
        $display("FAIL csum%0d got to=%b errs=%0d dn=%b e=%b want dn=%b e=%b", g, to,
                 write_errs(), done, err, g == 0, g == 1);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_toggle_and_random();
    test_length_bounds();
    test_start_ignored_restart();
    test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
